mem_stage_sub: RTL and testbench
================================

// Module: mem_stage_sub
// PURPOSE
//  Pipelined MEM-stage data-memory unit with sub-word load/store (byte/half) and configurable access latency.
//  Sits between EX/MEM and MEM/WB pipeline registers. Stores honour byte lanes; loads sign/zero-extend.
//  Raises m_stall while a multi-cycle access is pending so hazard logic freezes the upstream stages.
//  Store data is taken from a forwarded rt value when selected (MEM/WB write-back bypass).
// PARAMETERS
//  DEPTH_WORDS  3072  data-memory words; word index = m_addr[31:2]
//  WAIT_CYCLES  0     extra cycles per access (0 = single-cycle, no stall)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high
//  m_pc         in   32  PC of the instruction in MEM (trace only)
//  m_op         in   4   0 NONE,1 LW,2 LH,3 LHU,4 LB,5 LBU,6 SW,7 SH,8 SB; others = NONE
//  m_addr       in   32  ALU result: byte address, or pass-through value for non-memory ops
//  m_rd2        in   32  rt value from EX/MEM
//  fwd_rt_sel   in   1   1: store data = fwd_rt_data; 0: m_rd2
//  fwd_rt_data  in   32  MEM/WB write-back value
//  m_stall      out  1   access in progress; upstream must hold all inputs stable
//  m_done       out  1   memory access completes this cycle
//  m_result     out  32  load result (extended) for loads, else m_addr
// BEHAVIOUR
//  - FSM: IDLE, WAIT. cnt is a $clog2(WAIT_CYCLES+1)-bit counter.
//  - IDLE, op!=NONE, WAIT_CYCLES=0: m_done=1, m_stall=0; load data combinational; store commits at this edge.
//  - IDLE, op!=NONE, WAIT_CYCLES>0: m_stall=1, m_done=0; next state WAIT, cnt=1.
//  - WAIT: cnt<WAIT_CYCLES -> m_stall=1, cnt++; cnt==WAIT_CYCLES -> m_stall=0, m_done=1, store commits,
//    next IDLE. Each access costs exactly WAIT_CYCLES stall cycles.
//  - op NONE: m_stall=0, m_done=0, m_result=m_addr; no memory effect.
//  - Store lanes: SW all 4; SH lanes {a[1],0}..+1 with data[15:0]; SB lane a[1:0] with data[7:0]. Other lanes unchanged.
//  - Loads: LW word; LH/LHU half at a[1]; LB/LBU byte at a[1:0]; LH/LB sign-extend, LHU/LBU zero-extend.
//  - Misalignment: address low bits ignored as needed (LW/SW use a[31:2]; LH/SH ignore a[0]). No exception raised.
//  - Out of range (a[31:2] >= DEPTH_WORDS): store dropped, load returns 0, timing unchanged.
//  - Store data mux evaluated every cycle, so a forward arriving during WAIT is used at commit.
//  - Reset: all words cleared to 0, state IDLE, cnt=0; outputs next cycle m_stall=0, m_done=0.
//    Reset during WAIT aborts the access; pending store never commits.
//  - Reset outputs, combinational on inputs: m_result=m_addr (op NONE), m_stall=0, m_done=0.
//  - op changes during m_stall: protocol violation; result undefined, no X required.
// CONFIGURATION
//  MEM_TRACE_EN defined: each committed store prints at the commit edge
//    "@%h: *%h <= %h" (m_pc, word-aligned addr, full merged word).
//  MEM_TRACE_EN undefined: no $display; logic identical.
// TESTING
//  1. W=0: SW a=0x10 d=0x12345678; LW a=0x10 -> m_result=0x12345678, m_stall never 1.
//  2. W=0: SW 0x0 d=0; SB a=0x3 d=0x80; LW 0x0 -> 0x80000000; LB 0x3 -> 0xFFFFFF80; LBU -> 0x00000080.
//  3. W=0: SW 0x8 d=0xAABBCCDD; LH 0x8 -> 0xFFFFCCDD; LHU 0xA -> 0x0000AABB; SH 0xA d=0x1111; LW -> 0x1111CCDD.
//  4. W=2: SW 0x4 d=5 -> m_stall 1,1,0 with m_done in 3rd cycle; LW 0x4 next -> 5 after 2 stalls.
//  5. W=2: SW 0xC d=7, assert reset in 2nd cycle -> after reset LW 0xC -> 0, m_stall=0 after reset.
//  6. fwd_rt_sel=1 fwd_rt_data=0xDEADBEEF m_rd2=0: SW 0x20; LW 0x20 -> 0xDEADBEEF; a=0x3000 (out of range) LW -> 0.

Source files
------------

// File: rtl/mem_stage_sub.sv
// rtl/mem_stage_sub.sv - MEM-stage data memory with byte/half load/store and configurable access latency.
// Optional MEM_TRACE_EN: print each committed store as "@pc: *word_addr <= merged_word".
module mem_stage_sub #(
   parameter int DEPTH_WORDS = 3072,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_pc,
   input  logic [3:0]  m_op,
   input  logic [31:0] m_addr,
   input  logic [31:0] m_rd2,
   input  logic        fwd_rt_sel,
   input  logic [31:0] fwd_rt_data,
   output logic        m_stall,
   output logic        m_done,
   output logic [31:0] m_result
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

   localparam logic [3:0] OP_LW  = 4'd1;
   localparam logic [3:0] OP_LH  = 4'd2;
   localparam logic [3:0] OP_LHU = 4'd3;
   localparam logic [3:0] OP_LB  = 4'd4;
   localparam logic [3:0] OP_LBU = 4'd5;
   localparam logic [3:0] OP_SW  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SB  = 4'd8;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic            is_load, is_store, is_mem, in_range, mem_we;
   logic [AW-1:0]   idx;
   logic [31:0]     rd_word, st_data, wr_word;
   logic [15:0]     rd_half;
   logic [7:0]      rd_byte;
   logic            unused_pc;

   assign unused_pc = ^m_pc;

   // Reset forces the unit to look like op NONE on its outputs.
   assign is_load  = !reset && (m_op >= OP_LW) && (m_op <= OP_LBU);
   assign is_store = !reset && (m_op >= OP_SW) && (m_op <= OP_SB);
   assign is_mem   = is_load || is_store;

   assign in_range = (m_addr[31:2] < 30'(DEPTH_WORDS));
   assign idx      = m_addr[AW+1:2];
   assign rd_word  = in_range ? mem_q[idx] : '0;
   assign rd_half  = m_addr[1] ? rd_word[31:16] : rd_word[15:0];
   assign rd_byte  = rd_word[{m_addr[1:0], 3'b000} +: 8];
   assign st_data  = fwd_rt_sel ? fwd_rt_data : m_rd2;

   always_comb begin
      wr_word = rd_word;
      case (m_op)
         OP_SW: wr_word = st_data;
         OP_SH: if (m_addr[1]) wr_word[31:16] = st_data[15:0];
                else           wr_word[15:0]  = st_data[15:0];
         OP_SB: wr_word[{m_addr[1:0], 3'b000} +: 8] = st_data[7:0];
         default: wr_word = rd_word;
      endcase
   end

   always_comb begin
      m_result = m_addr;
      if (is_load) begin
         case (m_op)
            OP_LW:   m_result = rd_word;
            OP_LH:   m_result = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  m_result = {16'h0000, rd_half};
            OP_LB:   m_result = {{24{rd_byte[7]}}, rd_byte};
            default: m_result = {24'h000000, rd_byte};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (is_mem && WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = CW'(1);
         end
         default: if (cnt_q == CNT_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      endcase
   end

   always_comb begin
      m_stall = 1'b0;
      m_done  = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IDLE: if (is_mem) begin
               if (WAIT_CYCLES == 0) m_done  = 1'b1;
               else                  m_stall = 1'b1;
            end
            default: if (cnt_q == CNT_LAST) m_done  = 1'b1;
                     else                   m_stall = 1'b1;
         endcase
      end
   end

   assign mem_we = m_done && is_store && in_range;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[idx] <= wr_word;
`ifdef MEM_TRACE_EN
         $display("@%h: *%h <= %h", m_pc, {m_addr[31:2], 2'b00}, wr_word);
`else
`endif
      end
   end
endmodule

// File: tb/tb_mem_stage_sub.sv
// tb/tb_mem_stage_sub.sv - randomized check of mem_stage_sub (0 and 2 wait cycles) against a byte-array model.
module tb_mem_stage_sub;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m_pc, m_addr, m_rd2, fwd_rt_data;
   logic [3:0]  m_op;
   logic        fwd_rt_sel;
   logic        stall0, done0, stall2, done2;
   logic [31:0] res0, res2;

   int errors = 0;
   int checks = 0;
   logic [7:0] mb [0:12287];

   always #5 clk = ~clk;

   mem_stage_sub #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset(reset), .m_pc(m_pc), .m_op(m_op), .m_addr(m_addr), .m_rd2(m_rd2),
      .fwd_rt_sel(fwd_rt_sel), .fwd_rt_data(fwd_rt_data),
      .m_stall(stall0), .m_done(done0), .m_result(res0));

   mem_stage_sub #(.DEPTH_WORDS(3072), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .reset(reset), .m_pc(m_pc), .m_op(m_op), .m_addr(m_addr), .m_rd2(m_rd2),
      .fwd_rt_sel(fwd_rt_sel), .fwd_rt_data(fwd_rt_data),
      .m_stall(stall2), .m_done(done2), .m_result(res2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a);
      int b;
      logic [15:0] h;
      logic [7:0] by;
      if (op < 4'd1 || op > 4'd5) return a;
      if (a >= 32'd12288) return 32'h0;
      if (op == 4'd1) begin
         b = int'(a & ~32'd3);
         return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
      if (op == 4'd2 || op == 4'd3) begin
         b = int'(a & ~32'd1);
         h = {mb[b+1], mb[b]};
         return (op == 4'd2) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      by = mb[int'(a)];
      return (op == 4'd4) ? {{24{by[7]}}, by} : {24'h0, by};
   endfunction

   task automatic ref_store(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
      int b;
      if (a >= 32'd12288) return;
      if (op == 4'd6) begin
         b = int'(a & ~32'd3);
         for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
      end else if (op == 4'd7) begin
         b = int'(a & ~32'd1);
         mb[b] = d[7:0];
         mb[b+1] = d[15:8];
      end else if (op == 4'd8) begin
         mb[int'(a)] = d[7:0];
      end
   endtask

   // Both instances see the same access; inputs held until the 2-wait instance finishes.
   task automatic acc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                      input logic sel, input logic [31:0] fd, input logic late, input logic [31:0] late_d);
      logic [31:0] exp, sdata;
      int stalls;
      logic seen;
      exp = ref_res(op, a);
      sdata = sel ? fd : d;
      m_op = op; m_addr = a; m_rd2 = d; fwd_rt_sel = sel; fwd_rt_data = fd;
      m_pc = m_pc + 32'd4;
      stalls = 0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check($sformatf("w0_done op%0d a=%h", op, a), {31'b0, done0}, 32'd1);
            check($sformatf("w0_stall op%0d a=%h", op, a), {31'b0, stall0}, 32'd0);
            check($sformatf("w0_result op%0d a=%h", op, a), res0, exp);
         end
         if (done2) begin
            check($sformatf("w2_result op%0d a=%h", op, a), res2, exp);
            check("w2_stall_at_done", {31'b0, stall2}, 32'd0);
            seen = 1'b1;
            break;
         end
         check("w2_stall_pending", {31'b0, stall2}, 32'd1);
         stalls++;
         if (late && c == 0) begin
            m_rd2 = late_d;
            fwd_rt_data = late_d;
            sdata = late_d;
         end
         @(posedge clk); #1;
      end
      check("w2_done_seen", {31'b0, seen}, 32'd1);
      check("w2_stall_cycles", stalls, 32'd2);
      @(posedge clk); #1;
      ref_store(op, a, sdata);
      m_op = 4'd0;
   endtask

   task automatic none_check(input logic [3:0] op, input logic [31:0] a);
      m_op = op; m_addr = a;
      @(negedge clk);
      check("none_w0_result", res0, a);
      check("none_w2_result", res2, a);
      check("none_flags", {28'b0, stall0, done0, stall2, done2}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_op = 4'd1;
      m_addr = 32'h0000_0044;
      @(negedge clk);
      check("rst_result", res2, 32'h0000_0044);
      check("rst_flags", {28'b0, stall0, done0, stall2, done2}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_op = 4'd0;
      for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      int r;
      reset = 1'b1; m_pc = 32'h0000_1000; m_op = 4'd0; m_addr = '0; m_rd2 = '0;
      fwd_rt_sel = 1'b0; fwd_rt_data = '0;
      do_reset();
      none_check(4'd0, 32'h1234_5678);
      acc(4'd1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      acc(4'd6, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      acc(4'd6, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd8, 32'h3, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd4, 32'h3, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd5, 32'h3, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      acc(4'd6, 32'h8, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd2, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd3, 32'hA, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd7, 32'hA, 32'h1111, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      acc(4'd6, 32'h4, 32'h5, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      // Reset in the second cycle of a stalled store aborts it.
      m_op = 4'd6; m_addr = 32'hC; m_rd2 = 32'h7; fwd_rt_sel = 1'b0;
      @(negedge clk);
      check("abort_stall_first", {31'b0, stall2}, 32'd1);
      @(posedge clk); #1;
      do_reset();
      none_check(4'd0, 32'hC);
      acc(4'd1, 32'hC, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

      acc(4'd6, 32'h20, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0);
      acc(4'd1, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h3000, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd6, 32'h24, 32'h0, 1'b1, 32'h1111_2222, 1'b1, 32'hCAFE_F00D);
      acc(4'd1, 32'h24, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd6, 32'h4010, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
      acc(4'd1, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      none_check(4'd12, 32'h0000_0ABC);

      for (int n = 0; n < 300; n++) begin
         op = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom();
         else if (r == 1) a = 32'h3000 + 32'($urandom_range(0, 255));
         else             a = 32'($urandom_range(0, 63));
         if (op >= 4'd1 && op <= 4'd8)
            acc(op, a, $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                ($urandom_range(0, 3) == 0), $urandom());
         else
            none_check(op, a);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
